// File: rtl/alu_seq_pkg.sv
// Shared op-code enumeration and op-field width for the sequential ALU.
package alu_seq_pkg;
    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_ADC = 3'd2,
        ALU_SBC = 3'd3,
        ALU_SHR = 3'd4,
        ALU_ROR = 3'd5,
        ALU_MUL = 3'd6,
        ALU_NOP = 3'd7
    } alu_op_e;
endpackage

// File: rtl/alu_seq_if.sv
// Command/status bundle between a controller (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 8) ();
    logic                          start;
    logic [alu_seq_pkg::OP_W-1:0]  op;
    logic                          assertBar;
    logic [WIDTH-1:0]              areg;
    logic [WIDTH-1:0]              breg;
    logic                          busy;
    logic                          done;
    logic                          aIsZero;
    logic                          flagCarry;
    logic                          flagShift;
    logic                          flagZero;

    modport master (
        output start, op, assertBar, areg, breg,
        input  busy, done, aIsZero, flagCarry, flagShift, flagZero
    );

    modport slave (
        input  start, op, assertBar, areg, breg,
        output busy, done, aIsZero, flagCarry, flagShift, flagZero
    );
endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 fin_o,
    output logic                 recover_o,
    output logic [2*WIDTH-1:0]   prod_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_add;
    logic                 fin_q;

    assign busy_o    = (cnt_q != '0);
    assign acc_add   = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Last step: the product is complete in acc_add before the final edge.
    assign fin_o     = (cnt_q == CW'(1));
    assign prod_o    = acc_add;
    assign recover_o = fin_q;

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start_i) begin
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end else if (busy_o) begin
            cnt_d    = cnt_q - CW'(1);
            acc_d    = acc_add;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            fin_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            fin_q    <= fin_o;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with flags and a tri-state result bus.
// Define ALU_SEQ_MUL_EN to build the multi-cycle MUL; otherwise op 6 is a no-op.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    alu_seq_if.slave         bus,
    output wire [WIDTH-1:0]  dbus
);
    logic [WIDTH-1:0]    result_q, result_d;
    logic                carry_q, carry_d;
    logic                shift_q, shift_d;
    logic                zero_q, zero_d;
    logic                done_q, done_d;
    logic                busy, mul_fin, mul_recover, accept, wr;
    logic [2*WIDTH-1:0]  mul_prod;
    logic [WIDTH:0]      add_w, sub_w;
    logic                cin, bin;
    alu_op_e             op_e;

    assign op_e   = alu_op_e'(bus.op);
    // The cycle right after a MUL completes refuses new work.
    assign accept = bus.start && !busy && !mul_recover;

`ifdef ALU_SEQ_MUL_EN
    logic mul_start;
    assign mul_start = accept && (op_e == ALU_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (bus.areg),
        .b_i       (bus.breg),
        .busy_o    (busy),
        .fin_o     (mul_fin),
        .recover_o (mul_recover),
        .prod_o    (mul_prod)
    );
`else
    assign busy        = 1'b0;
    assign mul_fin     = 1'b0;
    assign mul_recover = 1'b0;
    assign mul_prod    = '0;
`endif

    assign cin   = (op_e == ALU_ADC) ? carry_q : 1'b0;
    assign bin   = (op_e == ALU_SBC) ? ~carry_q : 1'b0;
    assign add_w = {1'b0, bus.areg} + {1'b0, bus.breg} + {{WIDTH{1'b0}}, cin};
    assign sub_w = {1'b0, bus.areg} - {1'b0, bus.breg} - {{WIDTH{1'b0}}, bin};

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        shift_d  = shift_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        wr       = 1'b0;
        if (accept) begin
            done_d = 1'b1;
            case (op_e)
                ALU_ADD, ALU_ADC: begin
                    result_d = add_w[WIDTH-1:0];
                    carry_d  = add_w[WIDTH];
                    wr       = 1'b1;
                end
                ALU_SUB, ALU_SBC: begin
                    result_d = sub_w[WIDTH-1:0];
                    carry_d  = ~sub_w[WIDTH];
                    wr       = 1'b1;
                end
                ALU_SHR: begin
                    result_d = {shift_q, bus.areg[WIDTH-1:1]};
                    shift_d  = bus.areg[0];
                    wr       = 1'b1;
                end
                ALU_ROR: begin
                    result_d = {bus.areg[0], bus.areg[WIDTH-1:1]};
                    shift_d  = bus.areg[0];
                    wr       = 1'b1;
                end
`ifdef ALU_SEQ_MUL_EN
                ALU_MUL: done_d = 1'b0;
`endif
                default: ;
            endcase
        end
        if (mul_fin) begin
            result_d = mul_prod[WIDTH-1:0];
            carry_d  = |mul_prod[2*WIDTH-1:WIDTH];
            done_d   = 1'b1;
            wr       = 1'b1;
        end
        if (wr) zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            shift_q  <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            shift_q  <= shift_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.aIsZero   = (bus.areg == '0);
    assign bus.flagCarry = carry_q;
    assign bus.flagShift = shift_q;
    assign bus.flagZero  = zero_q;
    assign dbus          = bus.assertBar ? {WIDTH{1'bz}} : result_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed + random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 8;
    localparam int M = 256;

    logic        clk = 1'b0;
    logic        reset;
    wire  [7:0]  dbus;
    wire  [15:0] dbus16;
    int          checks = 0;
    int          failures = 0;
    int          m_res, m_c, m_s, m_z;
    logic [31:0] zexp;
    bit          im;

    alu_seq_if #(.WIDTH(8))  bus ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  dut   (.clk(clk), .reset(reset), .bus(bus),   .dbus(dbus));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16), .dbus(dbus16));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic model(input int o, input int a, input int b, output bit is_mul);
        int t;
        int brw;
        is_mul = 1'b0;
        case (o)
            0, 2: begin
                t     = a + b + ((o == 2) ? m_c : 0);
                m_res = t % M;
                m_c   = (t >= M) ? 1 : 0;
                m_z   = (m_res == 0) ? 1 : 0;
            end
            1, 3: begin
                brw   = (o == 3) ? 1 - m_c : 0;
                t     = a - b - brw;
                m_c   = (t >= 0) ? 1 : 0;
                m_res = (t + 2 * M) % M;
                m_z   = (m_res == 0) ? 1 : 0;
            end
            4: begin
                m_res = m_s * (M / 2) + a / 2;
                m_s   = a % 2;
                m_z   = (m_res == 0) ? 1 : 0;
            end
            5: begin
                m_res = (a % 2) * (M / 2) + a / 2;
                m_s   = a % 2;
                m_z   = (m_res == 0) ? 1 : 0;
            end
`ifdef ALU_SEQ_MUL_EN
            6: begin
                t      = a * b;
                m_res  = t % M;
                m_c    = (t >= M) ? 1 : 0;
                m_z    = (m_res == 0) ? 1 : 0;
                is_mul = 1'b1;
            end
`endif
            default: ;
        endcase
    endtask

    task automatic run_op(input int o, input int a, input int b);
        bit is_mul;
        int n;
        int prev;
        prev = m_res;
        @(negedge clk);
        bus.op    = 3'(o);
        bus.areg  = 8'(a);
        bus.breg  = 8'(b);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        model(o, a, b, is_mul);
        if (is_mul) begin
            n = 0;
            while (bus.busy === 1'b1 && n < 64) begin
                chk("mul_hold", 32'(dbus), 32'(prev));
                // Extra start and operand churn while busy must have no effect.
                bus.start = (n == 2);
                bus.op    = ALU_ADD;
                bus.areg  = 8'($urandom);
                bus.breg  = 8'($urandom);
                n++;
                @(negedge clk);
            end
            bus.start = 1'b0;
            chk("mul_busy_cycles", 32'(n), 32'(W));
        end
        chk("done", 32'(bus.done), 32'd1);
        chk("result", 32'(dbus), 32'(m_res));
        chk("carry", 32'(bus.flagCarry), 32'(m_c));
        chk("shift", 32'(bus.flagShift), 32'(m_s));
        chk("zero", 32'(bus.flagZero), 32'(m_z));
    endtask

    initial begin
        bus.start = 1'b0; bus.op = '0; bus.assertBar = 1'b0; bus.areg = '0; bus.breg = '0;
        bus16.start = 1'b0; bus16.op = '0; bus16.assertBar = 1'b0; bus16.areg = '0; bus16.breg = '0;
        m_res = 0; m_c = 0; m_s = 0; m_z = 0;
        zexp = '0;
        zexp[7:0] = 8'bz;
        reset = 1'b1;

        @(negedge clk);
        chk("rst_dbus", 32'(dbus), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_carry", 32'(bus.flagCarry), 32'd0);
        chk("rst_shift", 32'(bus.flagShift), 32'd0);
        chk("rst_zero", 32'(bus.flagZero), 32'd0);
        chk("azero_hi", 32'(bus.aIsZero), 32'd1);
        reset = 1'b0;
        bus.areg = 8'd5;
        #1;
        chk("azero_lo", 32'(bus.aIsZero), 32'd0);

        run_op(0, 200, 100);
        chk("add_200_100", 32'(dbus), 32'd44);
        chk("add_carry", 32'(bus.flagCarry), 32'd1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done), 32'd0);
        run_op(1, 5, 5);
        chk("sub_eq_zero", 32'(bus.flagZero), 32'd1);
        run_op(3, 3, 4);
        chk("sbc_res", 32'(dbus), 32'd255);
        chk("sbc_carry", 32'(bus.flagCarry), 32'd0);
        run_op(5, 1, 0);
        run_op(4, 3, 0);
        chk("shr_res", 32'(dbus), 32'h81);
        chk("shr_shift", 32'(bus.flagShift), 32'd1);
        run_op(5, 2, 0);
        chk("ror_res", 32'(dbus), 32'h01);
        chk("ror_shift", 32'(bus.flagShift), 32'd0);
        run_op(7, 9, 9);
        chk("nop_hold", 32'(dbus), 32'h01);

        @(negedge clk);
        bus.assertBar = 1'b1;
        #1;
        chk("dbus_hiz", 32'(dbus), zexp);
        bus.assertBar = 1'b0;
        #1;
        chk("dbus_drive", 32'(dbus), 32'h01);

`ifdef ALU_SEQ_MUL_EN
        run_op(6, 20, 13);
        chk("mul_20_13", 32'(dbus), 32'd4);
        chk("mul_carry", 32'(bus.flagCarry), 32'd1);
        // Start offered in the completion cycle is refused, accepted one later.
        bus.op = ALU_ADD; bus.areg = 8'd1; bus.breg = 8'd1; bus.start = 1'b1;
        @(negedge clk);
        chk("post_mul_refuse", 32'(bus.done), 32'd0);
        chk("post_mul_hold", 32'(dbus), 32'd4);
        @(negedge clk);
        bus.start = 1'b0;
        model(0, 1, 1, im);
        chk("post_mul_accept", 32'(bus.done), 32'd1);
        chk("post_mul_res", 32'(dbus), 32'd2);
`else
        run_op(6, 20, 13);
        chk("op6_nop", 32'(dbus), 32'h01);
`endif

        run_op(0, 255, 2);
        @(negedge clk);
        bus.op = ALU_MUL; bus.areg = 8'd20; bus.breg = 8'd13; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        @(negedge clk);
        @(negedge clk);
`endif
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_dbus", 32'(dbus), 32'd0);
        chk("midrst_carry", 32'(bus.flagCarry), 32'd0);
        chk("midrst_zero", 32'(bus.flagZero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_res = 0; m_c = 0; m_s = 0; m_z = 0;
        run_op(0, 1, 1);
        chk("after_rst_add", 32'(dbus), 32'd2);

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            @(negedge clk);
            chk("rand_done_low", 32'(bus.done), 32'd0);
        end

        @(negedge clk);
        bus16.op = ALU_ADD; bus16.areg = 16'hFFFF; bus16.breg = 16'h0001; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        chk("w16_done", 32'(bus16.done), 32'd1);
        chk("w16_res", 32'(dbus16), 32'd0);
        chk("w16_carry", 32'(bus16.flagCarry), 32'd1);
        chk("w16_zero", 32'(bus16.flagZero), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
